// File: rtl/ps2_scan_ctrl.sv
// PS/2 scancode prefix parser: folds E0/F0 prefixes into extended/break flags
// and queues decoded key events for a downstream decoder with a ready handshake.
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no prefix pending
// EXT     | E0 seen, next data byte is an extended key
// BRK     | F0 seen, next data byte is a key release
// EXT_BRK | E0 F0 seen, next data byte is an extended release
module ps2_scan_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PFX_TIMEOUT = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pc2_clk,
    input  logic                          rx_ro,
    input  logic [7:0]                    rx_data,
    input  logic                          dc_ready,
    output logic                          dc_strobe,
    output logic [7:0]                    dc_code,
    output logic                          dc_ext,
    output logic                          dc_break,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PFX_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LOAD = CW'(PFX_TIMEOUT);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic          pc2_m, pc2_s;
    logic          armed;
    logic          accept_cond;
    logic          acc;
    logic [7:0]    byte_q;
    logic [CW-1:0] to_cnt;
    logic          timeout;
    logic          push_req;
    logic          ent_ext, ent_brk;
    logic          push_vld;
    logic [9:0]    push_ent;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc2_m <= 1'b1;
            pc2_s <= 1'b1;
        end else begin
            pc2_m <= pc2_clk;
            pc2_s <= pc2_m;
        end
    end

    // One byte per low phase of the PS/2 clock, however long rx_ro stays up.
    assign accept_cond = rx_ro & armed & ~pc2_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b1;
            acc    <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            acc <= accept_cond;
            if (accept_cond) begin
                armed  <= 1'b0;
                byte_q <= rx_data;
            end else if (pc2_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (accept_cond) begin
            to_cnt <= TO_LOAD;
        end else if (state != ST_IDLE && to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign timeout = (state != ST_IDLE) && (to_cnt == '0) && !acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            case (byte_q)
                8'hE0: state_nxt = ST_EXT;
                8'hF0: begin
                    case (state)
                        ST_IDLE:    state_nxt = ST_BRK;
                        ST_EXT:     state_nxt = ST_EXT_BRK;
                        ST_BRK:     state_nxt = ST_BRK;
                        ST_EXT_BRK: state_nxt = ST_EXT_BRK;
                        default:    state_nxt = ST_IDLE;
                    endcase
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        push_req = 1'b0;
        ent_ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
        ent_brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
        if (acc) begin
            case (byte_q)
                8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE: push_req = 1'b0;
                default:                           push_req = 1'b1;
            endcase
        end
    end

    // Registered push keeps the parser decode off the FIFO write path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_vld <= 1'b0;
            push_ent <= '0;
        end else begin
            push_vld <= push_req;
            if (push_req) begin
                push_ent <= {ent_ext, ent_brk, byte_q};
            end
        end
    end

    assign full  = (level == DEPTH_L);
    assign pop   = (level != '0) && dc_ready && !dc_strobe;
    assign wr_en = push_vld && (!full || pop);

    // When full, push and pop share a slot; the read sees the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push_vld && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_strobe <= 1'b0;
            dc_code   <= 8'h00;
            dc_ext    <= 1'b0;
            dc_break  <= 1'b0;
        end else begin
            dc_strobe <= pop;
            if (pop) begin
                {dc_ext, dc_break, dc_code} <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a prefix-flag model predicts key events,
// a negedge monitor pops and compares every strobe the decoder port presents.
module tb_ps2_scan_ctrl;

    localparam int DEPTH = 4;
    localparam int PTO   = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pc2_clk = 1'b1;
    logic       rx_ro = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       dc_ready = 1'b1;
    logic       dc_strobe;
    logic [7:0] dc_code;
    logic       dc_ext;
    logic       dc_break;
    logic       ovf;
    logic [$clog2(DEPTH):0] level;

    ps2_scan_ctrl #(.FIFO_DEPTH(DEPTH), .PFX_TIMEOUT(PTO)) dut (
        .clk(clk), .rst_n(rst_n), .pc2_clk(pc2_clk), .rx_ro(rx_ro),
        .rx_data(rx_data), .dc_ready(dc_ready), .dc_strobe(dc_strobe),
        .dc_code(dc_code), .dc_ext(dc_ext), .dc_break(dc_break),
        .ovf(ovf), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t  expq[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_ext = 0, m_brk = 0, exp_ovf = 0, hold_phase = 0, rand_ready = 0;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: E0 sets ext and clears brk, F0 sets brk, control bytes clear,
    // anything else is a key event carrying the current flags.
    function automatic void model_byte(input logic [7:0] b);
        ev_t e;
        case (b)
            8'hE0: begin m_ext = 1; m_brk = 0; end
            8'hF0: m_brk = 1;
            8'hAA, 8'hFA, 8'hEE: begin m_ext = 0; m_brk = 0; end
            default: begin
                e.code = b; e.ext = m_ext; e.brk = m_brk;
                if (hold_phase && expq.size() >= DEPTH) exp_ovf = 1;
                else expq.push_back(e);
                m_ext = 0; m_brk = 0;
            end
        endcase
    endfunction

    function automatic logic [7:0] rand_code();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hE0 || b == 8'hF0 || b == 8'hAA || b == 8'hFA || b == 8'hEE);
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        model_byte(b);
        @(negedge clk);
        rx_data = b; pc2_clk = 1'b0; rx_ro = 1'b1;
        repeat (hold) @(negedge clk);
        rx_ro = 1'b0; pc2_clk = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && expq.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain_queue", 16'(expq.size()), 16'd0);
        check("drain_level", 16'(level), 16'd0);
    endtask

    logic [7:0] last_code = 8'h00;
    logic       last_ext = 1'b0, last_brk = 1'b0, prev_strobe = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            check("rst_strobe", 16'(dc_strobe), 16'd0);
            check("rst_out", {6'd0, dc_ext, dc_break, dc_code}, 16'd0);
            check("rst_level", 16'(level), 16'd0);
            check("rst_ovf", 16'(ovf), 16'd0);
            last_code = 8'h00; last_ext = 1'b0; last_brk = 1'b0; prev_strobe = 1'b0;
        end else begin
            if (dc_strobe) begin
                check("strobe_gap", 16'(prev_strobe), 16'd0);
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got code %0h expected none at %0t", dc_code, $time);
                end else begin
                    e = expq.pop_front();
                    check("ev_code", 16'(dc_code), 16'(e.code));
                    check("ev_ext", 16'(dc_ext), 16'(e.ext));
                    check("ev_brk", 16'(dc_break), 16'(e.brk));
                end
                last_code = dc_code; last_ext = dc_ext; last_brk = dc_break;
            end else begin
                check("out_hold", {6'd0, dc_ext, dc_break, dc_code},
                      {6'd0, last_ext, last_brk, last_code});
            end
            prev_strobe = dc_strobe;
        end
    end

    always @(negedge clk) begin
        if (rand_ready) dc_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single make, then break of the same key; then extended release
        send_byte(8'h1C, 5, 6);
        send_byte(8'hF0, 5, 6);
        send_byte(8'h1C, 5, 6);
        send_byte(8'hE0, 4, 3);
        send_byte(8'hF0, 6, 5);
        send_byte(8'h75, 4, 4);
        drain();

        // latency: falling pc2 at N0 -> accept at 3rd edge -> strobe visible at N6
        model_byte(8'h5A);
        @(negedge clk);
        rx_data = 8'h5A; pc2_clk = 1'b0; rx_ro = 1'b1;
        repeat (4) @(negedge clk);
        rx_ro = 1'b0; pc2_clk = 1'b1;
        @(negedge clk);
        check("latency_early", 16'(dc_strobe), 16'd0);
        @(negedge clk);
        check("latency_on_time", 16'(dc_strobe), 16'd1);
        drain();

        // long rx_ro hold and a second ready within the same low phase
        model_byte(8'h1C);
        @(negedge clk);
        rx_data = 8'h1C; pc2_clk = 1'b0; rx_ro = 1'b1;
        repeat (200) @(negedge clk);
        rx_ro = 1'b0;
        repeat (3) @(negedge clk);
        rx_data = 8'h33; rx_ro = 1'b1;
        repeat (10) @(negedge clk);
        rx_ro = 1'b0; pc2_clk = 1'b1;
        repeat (6) @(negedge clk);
        drain();

        // overflow with the decoder stalled
        dc_ready = 1'b0; hold_phase = 1;
        for (int i = 0; i < 6; i++) send_byte(rand_code(), 4, 4);
        repeat (5) @(negedge clk);
        check("ovf_level", 16'(level), 16'(DEPTH));
        check("ovf_model_level", 16'(level), 16'(expq.size()));
        check("ovf_flag", 16'(ovf), 16'(exp_ovf));
        hold_phase = 0; dc_ready = 1'b1;
        drain();
        check("ovf_sticky", 16'(ovf), 16'd1);

        // reset in the middle of a prefix with queued events
        dc_ready = 1'b0; hold_phase = 1;
        send_byte(rand_code(), 4, 4);
        send_byte(rand_code(), 4, 4);
        send_byte(8'hE0, 4, 4);
        send_byte(8'hF0, 4, 4);
        repeat (4) @(negedge clk);
        check("pre_rst_level", 16'(level), 16'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        expq.delete(); m_ext = 0; m_brk = 0; exp_ovf = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        hold_phase = 0; dc_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_ovf", 16'(ovf), 16'd0);
        send_byte(8'h29, 5, 5);
        drain();

        // stale prefix expires
        send_byte(8'hE0, 4, 4);
        repeat (PTO + 20) @(negedge clk);
        m_ext = 0; m_brk = 0;
        send_byte(8'h6B, 4, 4);
        drain();

        // randomized traffic with a flaky decoder
        rand_ready = 1;
        for (int i = 0; i < 80; i++) begin
            int k;
            logic [7:0] b;
            k = $urandom_range(0, 9);
            if (k < 2)       b = 8'hE0;
            else if (k < 4)  b = 8'hF0;
            else if (k == 4) begin
                case ($urandom_range(0, 2))
                    0:       b = 8'hAA;
                    1:       b = 8'hFA;
                    default: b = 8'hEE;
                endcase
            end else         b = rand_code();
            send_byte(b, $urandom_range(4, 8), $urandom_range(3, 8));
        end
        rand_ready = 0;
        dc_ready = 1'b1;
        drain();
        check("final_ovf", 16'(ovf), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of decoded key events buffered; it SHALL be a power of two, minimum 2.
REQ-002 The block SHALL have parameter PFX_TIMEOUT, default 50000, meaning the clk cycles a pending prefix (E0/F0) survives without a following byte.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port pc2_clk, input, 1 bit: raw PS/2 clock line, asynchronous to clk.
REQ-006 The block SHALL have port rx_ro, input, 1 bit: receiver "byte ready" level, may stay high for many cycles.
REQ-007 The block SHALL have port rx_data, input, 8 bits: received scancode byte, valid while rx_ro=1.
REQ-008 The block SHALL have port dc_ready, input, 1 bit: the decoder can accept an event.
REQ-009 The block SHALL have port dc_strobe, output, 1 bit: one-cycle event pulse to the decoder.
REQ-010 The block SHALL have port dc_code, output, 8 bits: event scancode, valid while dc_strobe=1.
REQ-011 The block SHALL have port dc_ext, output, 1 bit: the event was preceded by E0.
REQ-012 The block SHALL have port dc_break, output, 1 bit: the event was preceded by F0 (key release).
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky FIFO overflow flag.
REQ-014 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-015 pc2_clk SHALL pass through a 2-flop synchronizer (pc2_s) before any use.
REQ-016 Byte acceptance: at an edge where rx_ro=1, armed=1 and pc2_s=0, the block SHALL latch rx_data, assert an internal accept pulse for exactly one cycle, and clear armed.
REQ-017 armed SHALL be set at any edge where pc2_s=1; if that same edge also satisfies REQ-016, the clear SHALL win and no second acceptance SHALL occur until pc2_s is high again.
REQ-018 The parser FSM SHALL have states IDLE, EXT, BRK and EXT_BRK, and it SHALL process the latched byte on the edge following the accept pulse.
REQ-019 Transitions on 0xE0: IDLE->EXT; any other state->EXT, discarding the old prefix.
REQ-020 Transitions on 0xF0: IDLE->BRK; EXT->EXT_BRK; BRK->BRK; EXT_BRK->EXT_BRK.
REQ-021 On 0xAA, 0xFA or 0xEE the FSM SHALL drop the byte and go to IDLE, without pushing.
REQ-022 On any other byte the FSM SHALL push {ext, brk, byte} and go to IDLE, where ext=1 in EXT/EXT_BRK and brk=1 in BRK/EXT_BRK.
REQ-023 A cycle counter SHALL run while the FSM is not IDLE and SHALL reload on every accept; on reaching PFX_TIMEOUT the FSM SHALL return to IDLE with no push.
REQ-024 FIFO full with push and no pop: the entry SHALL be dropped and ovf SHALL be set to 1, and ovf SHALL hold until reset.
REQ-025 Push and pop in the same cycle, at any level including full: both SHALL succeed, level SHALL be unchanged and ovf SHALL be unaffected.
REQ-026 Output stage: at an edge where level>0, dc_ready=1 and dc_strobe=0, the block SHALL register dc_strobe=1 with the head entry on dc_code/dc_ext/dc_break and pop the FIFO.
REQ-027 Otherwise dc_strobe SHALL be 0, so strobes are at most every second cycle.
REQ-028 dc_code/dc_ext/dc_break SHALL hold their last values while dc_strobe=0.
REQ-029 Latency: with an empty FIFO and dc_ready=1, dc_strobe SHALL be high in the cycle following the third rising edge after the accepting edge.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and level SHALL never exceed FIFO_DEPTH.

Reset
REQ-031 While rst_n=0 the block SHALL hold: FSM=IDLE; armed=1; synchronizer flops=1; timeout counter, FIFO pointers and level=0; dc_strobe=0; dc_code=0x00; dc_ext=0; dc_break=0; ovf=0.
REQ-032 Reset asserted mid-sequence, for example after E0 F0, SHALL discard the prefix and all FIFO contents, and the first byte after release SHALL be parsed from IDLE.

Verification
REQ-033 Bytes 0x1C alone, then F0 1C -> two strobes: {code=0x1C, ext=0, brk=0}, then {code=0x1C, ext=0, brk=1}.
REQ-034 Bytes E0 F0 75 -> exactly one strobe with code=0x75, ext=1, brk=1; no strobe for the prefix bytes.
REQ-035 rx_ro held high for 200 cycles during one pc2_clk low period -> exactly one accept; no further accept until pc2_clk has gone high and low again.
REQ-036 dc_ready=0 with 6 data bytes sent (depth 4) -> level=4 and ovf=1; after dc_ready=1, exactly 4 strobes carrying the first 4 codes in order, separated by at least one idle cycle.
REQ-037 Byte E0, then nothing for PFX_TIMEOUT cycles, then 0x6B -> one strobe with code=0x6B, ext=0.
REQ-038 rst_n pulsed low after E0 F0 with level=2 -> level=0, ovf=0, no strobe issued; then byte 0x29 -> one strobe with code=0x29, ext=0, brk=0.
